// File: rtl/tlb_op_unit.sv
// tlb_op_unit: multi-cycle TLB maintenance engine (TLBP/TLBR/TLBWI/TLBWR) owning the entry array and Random
module tlb_op_unit #(
  parameter int TLB_ENTRIES = 16,
  parameter int TLB_INDEX = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic req_valid,
  output logic req_ready,
  input  logic [1:0] req_op,
  input  logic [31:0] entryhi,
  input  logic [31:0] entrylo0,
  input  logic [31:0] entrylo1,
  input  logic [31:0] index,
  input  logic [TLB_INDEX-1:0] wired,
  input  logic wired_we,
  output logic [TLB_INDEX-1:0] random,
  output logic resp_valid,
  output logic [31:0] resp_index,
  output logic [31:0] resp_entryhi,
  output logic [31:0] resp_entrylo0,
  output logic [31:0] resp_entrylo1
);
  typedef enum logic [2:0] {IDLE, PROBE, READ, WRITE, RESP} state_t;
  localparam logic [TLB_INDEX-1:0] MAX = TLB_INDEX'(TLB_ENTRIES - 1);
  state_t state;
  logic [18:0] e_vpn2 [TLB_ENTRIES];
  logic [7:0] e_asid [TLB_ENTRIES];
  logic e_g [TLB_ENTRIES];
  logic [24:0] e_lo0 [TLB_ENTRIES];
  logic [24:0] e_lo1 [TLB_ENTRIES];
  logic [TLB_INDEX-1:0] ptr, tgt;
  logic [18:0] l_vpn2;
  logic [7:0] l_asid;
  logic [25:0] l_lo0, l_lo1;
  logic hit;
  logic unused;
  assign unused = ^{entryhi[12:8], entrylo0[31:26], entrylo1[31:26], index[31:TLB_INDEX]};
  assign req_ready = state == IDLE;
  // V is deliberately ignored when probing
  assign hit = e_vpn2[ptr] == l_vpn2 && (e_g[ptr] || e_asid[ptr] == l_asid);
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      ptr <= '0;
      tgt <= '0;
      l_vpn2 <= '0;
      l_asid <= '0;
      l_lo0 <= '0;
      l_lo1 <= '0;
      random <= MAX;
      resp_valid <= 1'b0;
      resp_index <= '0;
      resp_entryhi <= '0;
      resp_entrylo0 <= '0;
      resp_entrylo1 <= '0;
      for (int i = 0; i < TLB_ENTRIES; i++) begin
        e_vpn2[i] <= '0;
        e_asid[i] <= '0;
        e_g[i] <= 1'b0;
        e_lo0[i] <= '0;
        e_lo1[i] <= '0;
      end
    end else begin
      random <= (wired_we || random == wired || random == '0) ? MAX : random - 1'b1;
      resp_valid <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          l_vpn2 <= entryhi[31:13];
          l_asid <= entryhi[7:0];
          l_lo0 <= entrylo0[25:0];
          l_lo1 <= entrylo1[25:0];
          tgt <= req_op == 2'b11 ? random : index[TLB_INDEX-1:0];
          ptr <= '0;
          state <= req_op == 2'b00 ? PROBE : req_op == 2'b01 ? READ : WRITE;
        end
        PROBE: if (hit || ptr == MAX) begin
          resp_index <= hit ? 32'(ptr) : 32'h8000_0000;
          resp_valid <= 1'b1;
          state <= RESP;
        end else ptr <= ptr + 1'b1;
        READ: begin
          resp_entryhi <= {e_vpn2[tgt], 5'b0, e_asid[tgt]};
          resp_entrylo0 <= {6'b0, e_lo0[tgt], e_g[tgt]};
          resp_entrylo1 <= {6'b0, e_lo1[tgt], e_g[tgt]};
          resp_valid <= 1'b1;
          state <= RESP;
        end
        WRITE: begin
          e_vpn2[tgt] <= l_vpn2;
          e_asid[tgt] <= l_asid;
          e_g[tgt] <= l_lo0[0] & l_lo1[0];
          e_lo0[tgt] <= l_lo0[25:1];
          e_lo1[tgt] <= l_lo1[25:1];
          resp_valid <= 1'b1;
          state <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/tlb_op_unit.md
Name: tlb_op_unit

Overview:
- Multi-cycle TLB maintenance engine that owns the TLB entry array and executes TLBP, TLBR, TLBWI and TLBWR.
- Sits directly upstream of the CP0 register file. It consumes CP0's entryhi, entrylo0, entrylo1, index and wired values, and produces the tu_op_resp fields that CP0 loads into Index (TLBP) or EntryHi/EntryLo0/EntryLo1 (TLBR).
- Also maintains the Random register.

Parameters:
TLB_ENTRIES, 16, number of TLB entries (power of two)
TLB_INDEX, 4, log2(TLB_ENTRIES)

Ports:
clk  input  1  clock
resetn  input  1  synchronous active-low reset
req_valid  input  1  operation request
req_ready  output  1  high only in IDLE
req_op  input  2  00=TLBP, 01=TLBR, 10=TLBWI, 11=TLBWR
entryhi  input  32  CP0 EntryHi {vpn2[31:13], 0[12:8], asid[7:0]}
entrylo0  input  32  CP0 EntryLo0 {0[31:26], pfn[25:6], C[5:3], D[2], V[1], G[0]}
entrylo1  input  32  CP0 EntryLo1, same layout
index  input  32  CP0 Index; bits [TLB_INDEX-1:0] used
wired  input  TLB_INDEX  CP0 Wired value
wired_we  input  1  CP0 write to Wired this cycle
random  output  TLB_INDEX  current Random value
resp_valid  output  1  one-cycle completion pulse
resp_index  output  32  TLBP result
resp_entryhi  output  32  TLBR result
resp_entrylo0  output  32  TLBR result
resp_entrylo1  output  32  TLBR result

Behaviour:
- Entry format: vpn2[18:0], asid[7:0], G, and for each of pages 0 and 1: pfn[19:0], C[2:0], D, V.
- Reset (resetn=0 at a clk edge, from any state, including mid-operation):
  - all entries zeroed; state=IDLE;
  - resp_valid=0; all resp_* = 0;
  - random = TLB_ENTRIES-1.
- States: IDLE, PROBE, READ, WRITE, RESP.
- IDLE: req_ready=1. The request is accepted at the edge where req_valid=1.
  - TLBP → PROBE, ptr=0.
  - TLBR → READ.
  - TLBWI/TLBWR → WRITE.
  - Latched at acceptance: entryhi, entrylo0, entrylo1, and target index. Target index = index[TLB_INDEX-1:0] for TLBR/TLBWI; = random for TLBWR.
- req_ready=0 in all other states. req_valid there is ignored, not queued.
- PROBE: each cycle compares entry[ptr].
  - Match: entry.vpn2 == latched vpn2 AND (entry.G OR entry.asid == latched asid). V is not checked.
  - First match → RESP with resp_index = zero-extended ptr.
  - No match and ptr==TLB_ENTRIES-1 → RESP with resp_index = 32'h8000_0000 (P bit set, index field 0).
  - Otherwise ptr++.
  - Lowest matching index wins.
- READ: one cycle, → RESP.
  - resp_entryhi = {vpn2, 5'b0, asid}.
  - resp_entrylo0 = {6'b0, pfn0, C0, D0, V0, G}; resp_entrylo1 likewise with page-1 fields.
  - Both lo words carry the single stored G.
- WRITE: one cycle. The entry at the latched target index is written at the edge leaving WRITE; → RESP.
  - Stored G = entrylo0.G AND entrylo1.G.
  - resp_index and resp_entry* keep their previous values.
- RESP: resp_valid=1 for exactly one cycle, → IDLE.
  - resp_* are stable from the RESP cycle until the next RESP.
- Latency, counted from the acceptance edge (cycle 0):
  - TLBP hit at entry k: resp_valid in cycle k+2.
  - TLBP miss: cycle TLB_ENTRIES+1.
  - TLBR, TLBWI, TLBWR: cycle 2.
- Random: updates every cycle in every state (except under reset).
  - If random == wired or random == 0: random ← TLB_ENTRIES-1.
  - Else: random ← random-1.
  - Wrap range is [wired, TLB_ENTRIES-1].
  - If wired ≥ TLB_ENTRIES-1, random stays TLB_ENTRIES-1.
  - wired_we=1 forces random ← TLB_ENTRIES-1, with priority over decrement.
  - TLBWR uses the value of random at its acceptance edge.
- Input changes to entryhi, entrylo0, entrylo1 or index after acceptance have no effect on the in-flight operation.

Test Plan:
- Reset, then TLBP with entryhi=32'h0000_0000 → match at entry 0 (all-zero entries, asid 0): resp_valid in cycle 2, resp_index=0.
- TLBWI index=5, entryhi=32'h1234_6005, lo0=32'h0000_0107, lo1=32'h0000_0217; then TLBR index=5 → resp_entryhi=32'h1234_6005, resp_entrylo0=32'h0000_0107, resp_entrylo1=32'h0000_0217.
- Rewrite entry 5 with lo0.G=1, lo1.G=0; TLBR index=5 → G bit [0] = 0 in both lo words. Then TLBP with entryhi vpn2 matching but asid=8'h7 → resp_index=32'h8000_0000 at cycle 17.
- With wired=4 and no wired_we for 30 cycles → random sequence 15,14,…,4,15; pulse wired_we → random=15 next cycle. Then TLBWR → entry at the sampled random is written; TLBP on its vpn2 returns that index.
- Entries 3 and 9 with the same vpn2 and G=1 → TLBP returns 3 in cycle 5. req_valid held high during PROBE → ignored, req_ready=0.
- Assert resetn=0 mid-PROBE → next cycle state IDLE, resp_valid=0, random=15; a subsequent TLBR of any index returns all-zero words.
